// File: rtl/skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/register.sv
// Write-enable gated register with asynchronous active-low clear.
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL)  q <= '0;
    else if (we)  q <= d;
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry elastic stage; ready/valid decode only from registered state.
// Optional SKID_BUFFER_FLUSH_EN adds a flush port that empties the buffer.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
`ifdef SKID_BUFFER_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  skid_state_t      state_q, state_d;
  logic             main_we, skid_we, main_from_skid;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign count     = state_q;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign main_d    = main_from_skid ? skid_q : in_data;

  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    skid_we        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: if (in_fire) begin
        state_d = ONE;
        main_we = 1'b1;
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          state_d = FULL;
          skid_we = 1'b1;
        end else if (in_fire && out_fire) begin
          main_we = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: if (out_fire) begin
        state_d        = ONE;
        main_we        = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
`ifdef SKID_BUFFER_FLUSH_EN
    // Flush overrides any handshake in the same cycle.
    if (flush) begin
      state_d = EMPTY;
      main_we = 1'b0;
      skid_we = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  register #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .rst_aL (rst_aL),
    .we     (main_we),
    .d      (main_d),
    .q      (main_q)
  );

  register #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .rst_aL (rst_aL),
    .we     (skid_we),
    .d      (in_data),
    .q      (skid_q)
  );

endmodule

// File: tb/tb_skid_buffer.sv
// Directed bench for skid_buffer: reset, streaming, backpressure, simultaneous
// push/pop, async reset mid-stream and (with SKID_BUFFER_FLUSH_EN) flush.
module tb_skid_buffer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_aL;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;
`ifdef SKID_BUFFER_FLUSH_EN
  logic             flush;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef SKID_BUFFER_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic ov, input logic [1:0] cnt,
                              input logic ir, input logic [31:0] od);
    check({tag, ".out_valid"}, 32'(ov), 32'(out_valid));
    check({tag, ".count"},     32'(cnt), 32'(count));
    check({tag, ".in_ready"},  32'(ir), 32'(in_ready));
    if (ov) check({tag, ".out_data"}, od, out_data);
  endtask

  initial begin
    rst_aL    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef SKID_BUFFER_FLUSH_EN
    flush     = 1'b0;
`endif
    #3;
    expect_state("reset", 1'b0, 2'd0, 1'b1, 32'h0);
    check("reset.out_data", out_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_aL = 1'b1;
    tick();
    expect_state("post_reset", 1'b0, 2'd0, 1'b1, 32'h0);
    check("post_reset.out_data", out_data, 32'h0);

    // Streaming: one item per cycle, occupancy stays at 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      expect_state($sformatf("stream%0d", i), 1'b1, 2'd1, 1'b1, 32'(i));
    end
    in_valid = 1'b0;
    tick();
    expect_state("stream_drain", 1'b0, 2'd0, 1'b1, 32'h0);

    // Backpressure: fill both entries, hold a third on in_valid.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    expect_state("bp_A", 1'b1, 2'd1, 1'b1, 32'hA);
    in_data = 32'hB;
    tick();
    expect_state("bp_B", 1'b1, 2'd2, 1'b0, 32'hA);
    in_data = 32'hC;
    tick();
    expect_state("bp_hold", 1'b1, 2'd2, 1'b0, 32'hA);
    tick();
    expect_state("bp_hold2", 1'b1, 2'd2, 1'b0, 32'hA);
    out_ready = 1'b1;
    tick();
    expect_state("bp_popA", 1'b1, 2'd1, 1'b1, 32'hB);
    tick();
    expect_state("bp_popB", 1'b1, 2'd1, 1'b1, 32'hC);
    in_valid = 1'b0;
    tick();
    expect_state("bp_popC", 1'b0, 2'd0, 1'b1, 32'h0);

    // Simultaneous push and pop while holding one entry.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    expect_state("sim_load5", 1'b1, 2'd1, 1'b1, 32'h5);
    out_ready = 1'b1;
    in_data   = 32'h6;
    tick();
    expect_state("sim_swap6", 1'b1, 2'd1, 1'b1, 32'h6);
    in_valid = 1'b0;
    tick();
    expect_state("sim_drain", 1'b0, 2'd0, 1'b1, 32'h0);

    // Async reset while full, asserted mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    expect_state("ar_full", 1'b1, 2'd2, 1'b0, 32'h11);
    in_valid = 1'b0;
    #2;
    rst_aL = 1'b0;
    #1;
    expect_state("ar_async", 1'b0, 2'd0, 1'b1, 32'h0);
    check("ar_async.out_data", out_data, 32'h0);
    @(negedge clk);
    rst_aL = 1'b1;
    tick();
    expect_state("ar_release", 1'b0, 2'd0, 1'b1, 32'h0);

`ifdef SKID_BUFFER_FLUSH_EN
    // Flush while full; the offered 0xF must never surface.
    in_valid = 1'b1;
    in_data  = 32'h31;
    tick();
    in_data = 32'h32;
    tick();
    expect_state("fl_full", 1'b1, 2'd2, 1'b0, 32'h31);
    flush   = 1'b1;
    in_data = 32'hF;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'h0);
    tick();
    expect_state("fl_flushed", 1'b0, 2'd0, 1'b1, 32'h0);
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_state("fl_after", 1'b0, 2'd0, 1'b1, 32'h0);
    // Flush with in_fire from EMPTY also drops the item.
    flush    = 1'b1;
    in_valid = 1'b1;
    tick();
    expect_state("fl_empty_drop", 1'b0, 2'd0, 1'b1, 32'h0);
    flush    = 1'b0;
    in_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
